// File: rtl/riscv_pipe_pkg.sv
// Shared types for the 5-stage pipeline control logic: forward-select
// encodings and the shadow-slot records the hazard unit keeps per stage.
package riscv_pipe_pkg;

  // Slots store register indices at a fixed upper width; cores with a
  // narrower REG_ADDR_W zero-extend their fields into it (REG_ADDR_W <= 8).
  localparam int unsigned REG_ADDR_MAX_W = 8;
  typedef logic [REG_ADDR_MAX_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = '0;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_WB    = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic      valid;
    reg_addr_t rs1;
    reg_addr_t rs2;
    logic      use1;
    logic      use2;
    reg_addr_t rd;
    logic      rw;
    logic      mr;
  } ex_slot_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
    logic      rw;
    logic      mr;
  } mem_slot_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
    logic      rw;
  } wb_slot_t;

  // A source register is produced by a slot when that slot holds a live
  // register write to it; x0 never counts as a producer.
  function automatic logic slot_match(input reg_addr_t r, input logic valid,
                                      input logic rw, input reg_addr_t rd);
    return valid & rw & (rd == r) & (r != REG_ZERO);
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// ID-stage decode fields in, pipeline control and counters out.
interface hazard_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  branch_taken;

  logic                  stall;
  logic                  bubble;
  logic                  flush;
  logic [1:0]            fwd_a;
  logic [1:0]            fwd_b;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_reg_write, id_mem_read, branch_taken,
    input  stall, bubble, flush, fwd_a, fwd_b, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_reg_write, id_mem_read, branch_taken,
    output stall, bubble, flush, fwd_a, fwd_b, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_unit_fwd_sel.sv
// EXE operand forward select: newest producer wins, loads in MEM are skipped
// because their data is not yet available on the EXE/MEM ALU result path.
module fwd_sel
  import riscv_pipe_pkg::*;
(
  input  logic      i_ex_valid,
  input  logic      i_use,
  input  reg_addr_t i_rs,
  input  mem_slot_t i_mem,
  input  wb_slot_t  i_wb,
  output fwd_sel_e  o_sel
);

  logic w_mem_hit;
  logic w_wb_hit;

  assign w_mem_hit = slot_match(i_rs, i_mem.valid, i_mem.rw, i_mem.rd) & ~i_mem.mr;
  assign w_wb_hit  = slot_match(i_rs, i_wb.valid, i_wb.rw, i_wb.rd);

  always_comb begin
    // NOTE: default first so every path assigns o_sel and no latch is inferred.
    o_sel = FWD_RF;
    if (i_ex_valid && i_use) begin
      if (w_mem_hit) begin
        o_sel = FWD_EXMEM;
      end else if (w_wb_hit) begin
        o_sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard control: shadows rd info for EXE/MEM/WB and derives
// load-use stalls, taken-branch flushes, operand forwarding and counters.
module hazard_unit
  import riscv_pipe_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int LOAD_LATENCY = 1,
  parameter int CNT_W        = 16
) (
  input logic           clock,
  input logic           reset,
  hazard_unit_if.slave  bus
);

  localparam logic LOAD_IN_MEM_BLOCKS = (LOAD_LATENCY >= 2);

  ex_slot_t         r_ex;
  mem_slot_t        r_mem;
  wb_slot_t         r_wb;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  ex_slot_t  w_id_slot;
  logic      w_need_rs1_ex;
  logic      w_need_rs2_ex;
  logic      w_need_rs1_mem;
  logic      w_need_rs2_mem;
  logic      w_load_use;
  logic      w_stall;
  fwd_sel_e  w_fwd_a;
  fwd_sel_e  w_fwd_b;

  assign w_id_slot = '{
    valid: bus.id_valid,
    rs1:   reg_addr_t'(bus.id_rs1),
    rs2:   reg_addr_t'(bus.id_rs2),
    use1:  bus.id_use_rs1,
    use2:  bus.id_use_rs2,
    rd:    reg_addr_t'(bus.id_rd),
    rw:    bus.id_reg_write,
    mr:    bus.id_mem_read
  };

  assign w_need_rs1_ex  = w_id_slot.use1 & slot_match(w_id_slot.rs1, r_ex.valid, r_ex.rw, r_ex.rd);
  assign w_need_rs2_ex  = w_id_slot.use2 & slot_match(w_id_slot.rs2, r_ex.valid, r_ex.rw, r_ex.rd);
  assign w_need_rs1_mem = w_id_slot.use1 & slot_match(w_id_slot.rs1, r_mem.valid, r_mem.rw, r_mem.rd);
  assign w_need_rs2_mem = w_id_slot.use2 & slot_match(w_id_slot.rs2, r_mem.valid, r_mem.rw, r_mem.rd);

  // With a registered data memory a load in MEM still has no usable data.
  assign w_load_use = w_id_slot.valid & (
                        (r_ex.mr & (w_need_rs1_ex | w_need_rs2_ex)) |
                        (LOAD_IN_MEM_BLOCKS & r_mem.mr & (w_need_rs1_mem | w_need_rs2_mem)));

  // A taken branch kills the stalled instruction anyway, so flush dominates.
  assign w_stall    = w_load_use & ~bus.branch_taken;
  assign bus.stall  = w_stall;
  assign bus.bubble = w_stall;
  assign bus.flush  = bus.branch_taken;

  fwd_sel u_fwd_a (
    .i_ex_valid (r_ex.valid),
    .i_use      (r_ex.use1),
    .i_rs       (r_ex.rs1),
    .i_mem      (r_mem),
    .i_wb       (r_wb),
    .o_sel      (w_fwd_a)
  );

  fwd_sel u_fwd_b (
    .i_ex_valid (r_ex.valid),
    .i_use      (r_ex.use2),
    .i_rs       (r_ex.rs2),
    .i_mem      (r_mem),
    .i_wb       (r_wb),
    .o_sel      (w_fwd_b)
  );

  assign bus.fwd_a     = w_fwd_a;
  assign bus.fwd_b     = w_fwd_b;
  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;

  // NOTE: sequential state uses non-blocking assignments so every slot
  // samples the pre-edge value of its upstream neighbour.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ex        <= '0;
      r_mem       <= '0;
      r_wb        <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_wb <= '{valid: r_mem.valid, rd: r_mem.rd, rw: r_mem.rw};
      if (bus.branch_taken) begin
        r_ex  <= '0;
        r_mem <= '0;
        if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end else begin
        r_mem <= '{valid: r_ex.valid, rd: r_ex.rd, rw: r_ex.rw, mr: r_ex.mr};
        r_ex  <= w_stall ? '0 : w_id_slot;
        if (w_stall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: two configurations (LOAD_LATENCY 1 / 16-bit
// counters and LOAD_LATENCY 2 / 4-bit counters) share one ID stimulus stream.
module tb_hazard_unit;

  typedef struct {
    bit valid;
    int rs1;
    int rs2;
    bit u1;
    bit u2;
    int rd;
    bit rw;
    bit mr;
  } ins_t;

  typedef struct {
    bit chk;
    bit stall;
    bit bubble;
    bit flush;
    int fa;
    int fb;
    int sc;
    int fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_unit_if #(.REG_ADDR_W(5), .CNT_W(16)) if0 ();
  hazard_unit_if #(.REG_ADDR_W(5), .CNT_W(4))  if1 ();

  assign if1.id_valid     = if0.id_valid;
  assign if1.id_rs1       = if0.id_rs1;
  assign if1.id_rs2       = if0.id_rs2;
  assign if1.id_use_rs1   = if0.id_use_rs1;
  assign if1.id_use_rs2   = if0.id_use_rs2;
  assign if1.id_rd        = if0.id_rd;
  assign if1.id_reg_write = if0.id_reg_write;
  assign if1.id_mem_read  = if0.id_mem_read;
  assign if1.branch_taken = if0.branch_taken;

  hazard_unit #(.REG_ADDR_W(5), .LOAD_LATENCY(1), .CNT_W(16)) dut0 (
    .clock (clk),
    .reset (rst),
    .bus   (if0.slave)
  );

  hazard_unit #(.REG_ADDR_W(5), .LOAD_LATENCY(2), .CNT_W(4)) dut1 (
    .clock (clk),
    .reset (rst),
    .bus   (if1.slave)
  );

  // Reference model: per configuration, the instructions in flight listed
  // by age (0 = in EXE, 1 = in MEM, 2 = in WB) plus the two event counts.
  ins_t flight [2][3];
  int   scnt [2];
  int   fcnt [2];
  int   lat  [2] = '{1, 2};
  int   cmax [2] = '{65535, 15};

  exp_t q0 [$];
  exp_t q1 [$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic ins_t mk(input int rd, input int rs1, input bit u1,
                              input int rs2, input bit u2, input bit rw, input bit mr);
    ins_t i;
    i.valid = 1'b1;
    i.rd = rd; i.rs1 = rs1; i.rs2 = rs2;
    i.u1 = u1; i.u2 = u2; i.rw = rw; i.mr = mr;
    return i;
  endfunction

  function automatic ins_t nop();
    ins_t i;
    i.valid = 1'b0;
    i.rd = 0; i.rs1 = 0; i.rs2 = 0;
    i.u1 = 1'b0; i.u2 = 1'b0; i.rw = 1'b0; i.mr = 1'b0;
    return i;
  endfunction

  function automatic bit writes(input ins_t i, input int r);
    return i.valid && i.rw && i.rd == r && r != 0;
  endfunction

  // Operand source seen by the instruction in EXE: the closest older
  // non-load producer, a producer retiring in WB, or the register file.
  function automatic int fwd_model(input int d, input bit use_it, input int r);
    if (!flight[d][0].valid || !use_it) return 0;
    if (writes(flight[d][1], r) && !flight[d][1].mr) return 1;
    if (writes(flight[d][2], r)) return 2;
    return 0;
  endfunction

  // A load whose data is not yet forwardable sits within its latency window.
  function automatic bit load_use_model(input int d, input ins_t id);
    if (!id.valid) return 1'b0;
    for (int age = 0; age < lat[d]; age++) begin
      if (flight[d][age].mr &&
          ((id.u1 && writes(flight[d][age], id.rs1)) ||
           (id.u2 && writes(flight[d][age], id.rs2))))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  // One clock cycle: present ID inputs, record expected outputs, advance model.
  task automatic step(input ins_t id, input bit bt, input bit rs, output bit stalled);
    exp_t e;
    bit   lu;
    @(posedge clk);
    #1;
    rst              = rs;
    if0.id_valid     = id.valid;
    if0.id_rs1       = 5'(id.rs1);
    if0.id_rs2       = 5'(id.rs2);
    if0.id_use_rs1   = id.u1;
    if0.id_use_rs2   = id.u2;
    if0.id_rd        = 5'(id.rd);
    if0.id_reg_write = id.rw;
    if0.id_mem_read  = id.mr;
    if0.branch_taken = bt;
    stalled = 1'b0;
    for (int d = 0; d < 2; d++) begin
      lu       = load_use_model(d, id);
      e.chk    = !rs;
      e.flush  = bt;
      e.stall  = lu && !bt;
      e.bubble = lu && !bt;
      e.fa     = fwd_model(d, flight[d][0].u1, flight[d][0].rs1);
      e.fb     = fwd_model(d, flight[d][0].u2, flight[d][0].rs2);
      e.sc     = scnt[d];
      e.fc     = fcnt[d];
      if (d == 0) q0.push_back(e); else q1.push_back(e);
      stalled |= e.stall;
      if (rs) begin
        for (int a = 0; a < 3; a++) flight[d][a] = nop();
        scnt[d] = 0;
        fcnt[d] = 0;
      end else if (bt) begin
        flight[d][2] = flight[d][1];
        flight[d][1] = nop();
        flight[d][0] = nop();
        if (fcnt[d] < cmax[d]) fcnt[d]++;
      end else begin
        flight[d][2] = flight[d][1];
        flight[d][1] = flight[d][0];
        flight[d][0] = e.stall ? nop() : id;
        if (e.stall && scnt[d] < cmax[d]) scnt[d]++;
      end
    end
  endtask

  // Issue an instruction as the core would: hold it in ID while stalled.
  task automatic issue(input ins_t id);
    bit st;
    int guard = 0;
    do begin
      step(id, 1'b0, 1'b0, st);
      guard++;
    end while (st && guard < 8);
    if (guard >= 8) check("stall_bounded", guard, 0);
  endtask

  function automatic ins_t rand_ins();
    ins_t i;
    if ($urandom_range(0, 9) == 0) return nop();
    i.valid = 1'b1;
    i.rs1 = $urandom_range(0, 7);
    i.rs2 = $urandom_range(0, 7);
    i.rd  = $urandom_range(0, 7);
    i.u1  = $urandom_range(0, 1);
    i.u2  = $urandom_range(0, 1);
    i.rw  = $urandom_range(0, 4) != 0;
    i.mr  = i.rw && ($urandom_range(0, 9) < 3);
    return i;
  endfunction

  // Monitor: every falling edge compare both DUTs against their queued expectations.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        if (e.chk) begin
          check("ll1_stall",  int'(if0.stall),     int'(e.stall));
          check("ll1_bubble", int'(if0.bubble),    int'(e.bubble));
          check("ll1_flush",  int'(if0.flush),     int'(e.flush));
          check("ll1_fwd_a",  int'(if0.fwd_a),     e.fa);
          check("ll1_fwd_b",  int'(if0.fwd_b),     e.fb);
          check("ll1_scnt",   int'(if0.stall_cnt), e.sc);
          check("ll1_fcnt",   int'(if0.flush_cnt), e.fc);
        end
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        if (e.chk) begin
          check("ll2_stall",  int'(if1.stall),     int'(e.stall));
          check("ll2_bubble", int'(if1.bubble),    int'(e.bubble));
          check("ll2_flush",  int'(if1.flush),     int'(e.flush));
          check("ll2_fwd_a",  int'(if1.fwd_a),     e.fa);
          check("ll2_fwd_b",  int'(if1.fwd_b),     e.fb);
          check("ll2_scnt",   int'(if1.stall_cnt), e.sc);
          check("ll2_fcnt",   int'(if1.flush_cnt), e.fc);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   st;
    ins_t lw7, add87, ins;
    lw7   = mk(7, 1, 1'b1, 0, 1'b0, 1'b1, 1'b1);
    add87 = mk(8, 7, 1'b1, 1, 1'b1, 1'b1, 1'b0);

    if0.id_valid = 1'b0; if0.id_rs1 = '0; if0.id_rs2 = '0;
    if0.id_use_rs1 = 1'b0; if0.id_use_rs2 = 1'b0; if0.id_rd = '0;
    if0.id_reg_write = 1'b0; if0.id_mem_read = 1'b0; if0.branch_taken = 1'b0;
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 3; a++) flight[d][a] = nop();
      scnt[d] = 0;
      fcnt[d] = 0;
    end

    step(nop(), 1'b0, 1'b1, st);
    step(nop(), 1'b0, 1'b1, st);
    step(nop(), 1'b0, 1'b0, st);
    @(negedge clk);
    check("reset_stall", int'(if0.stall), 0);
    check("reset_fwd_a", int'(if1.fwd_a), 0);
    check("reset_cnt",   int'(if1.stall_cnt) + int'(if0.flush_cnt), 0);

    // add x3,x1,x2 ; sub x4,x3,x5
    issue(mk(3, 1, 1'b1, 2, 1'b1, 1'b1, 1'b0));
    issue(mk(4, 3, 1'b1, 5, 1'b1, 1'b1, 1'b0));
    issue(nop());
    @(negedge clk);
    check("b2b_fwd_a", int'(if0.fwd_a), 1);

    // add x3 ; nop ; or x6,x3,x3
    issue(mk(3, 1, 1'b1, 2, 1'b1, 1'b1, 1'b0));
    issue(nop());
    issue(mk(6, 3, 1'b1, 3, 1'b1, 1'b1, 1'b0));
    issue(nop());
    @(negedge clk);
    check("dist2_fwd_b", int'(if1.fwd_b), 2);
    repeat (3) issue(nop());

    // lw x7 ; add x8,x7,x1
    issue(lw7);
    step(add87, 1'b0, 1'b0, st);
    @(negedge clk);
    check("lu_stall_first", int'(if1.stall) + int'(if0.bubble), 2);
    issue(add87);
    repeat (3) issue(nop());

    // Taken branch while a load-use stall is pending in ID
    issue(lw7);
    step(add87, 1'b1, 1'b0, st);
    @(negedge clk);
    check("br_flush_over_stall", int'(if0.stall), 0);
    step(add87, 1'b0, 1'b0, st);
    repeat (3) issue(nop());

    // lw x0 ; add x9,x0,x0
    issue(mk(0, 1, 1'b1, 0, 1'b0, 1'b1, 1'b1));
    step(mk(9, 0, 1'b1, 0, 1'b1, 1'b1, 1'b0), 1'b0, 1'b0, st);
    @(negedge clk);
    check("x0_no_stall", int'(if1.stall), 0);
    repeat (3) issue(nop());

    // Drive enough load-use pairs to saturate the 4-bit stall counter
    for (int k = 0; k < 12; k++) begin
      issue(lw7);
      issue(add87);
    end
    issue(nop());
    @(negedge clk);
    check("sat_stall_cnt", int'(if1.stall_cnt), 15);

    // Reset asserted mid-stall
    issue(lw7);
    step(add87, 1'b0, 1'b1, st);
    step(add87, 1'b0, 1'b0, st);
    @(negedge clk);
    check("rst_mid_stall", int'(if1.stall), 0);
    check("rst_cnt_clear", int'(if0.stall_cnt) + int'(if1.flush_cnt), 0);
    repeat (3) issue(nop());

    // Randomised traffic with occasional branches and resets
    for (int n = 0; n < 3000; n++) begin
      ins = rand_ins();
      step(ins, ($urandom_range(0, 11) == 0), ($urandom_range(0, 199) == 0), st);
    end
    repeat (4) step(nop(), 1'b0, 1'b0, st);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
